// File: rtl/debounce_bank.sv
// Multi-channel button debouncer: 2-flop synchroniser, per-channel stability counter, press/release pulses.
// Optional auto-repeat of press_pulse while held is enabled by defining DEBOUNCE_BANK_REPEAT_EN.
module debounce_bank #(
    parameter int NUM_CH        = 4,
    parameter int CNT_W         = 20,
    parameter int STABLE_CNT    = 500000,
    parameter int ACTIVE_LOW    = 0,
    parameter int REPEAT_DELAY  = 50000000,
    parameter int REPEAT_PERIOD = 10000000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] button_in,
    output logic [NUM_CH-1:0] button_out,
    output logic [NUM_CH-1:0] press_pulse,
    output logic [NUM_CH-1:0] release_pulse,
    output logic              any_press
);

    if (NUM_CH < 1 || NUM_CH > 32 || STABLE_CNT < 2 ||
        longint'(STABLE_CNT) > ((64'd1 << CNT_W) - 64'd1) ||
        REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_cfg
        $error("debounce_bank: parameter out of range");
    end

    logic [NUM_CH-1:0]            raw_s;
    logic [NUM_CH-1:0]            sync1_q, sync1_d;
    logic [NUM_CH-1:0]            sync2_q, sync2_d;
    logic [NUM_CH-1:0]            level_q, level_d;
    logic [NUM_CH-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [NUM_CH-1:0]            press_q, press_d;
    logic [NUM_CH-1:0]            release_q, release_d;
    logic                         any_q, any_d;
    logic [NUM_CH-1:0]            rep_fire_s;

    assign raw_s = (ACTIVE_LOW != 0) ? ~button_in : button_in;

`ifdef DEBOUNCE_BANK_REPEAT_EN
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int REP_W   = $clog2(REP_MAX + 1);

    logic [NUM_CH-1:0][REP_W-1:0] rep_cnt_q, rep_cnt_d;
    logic [NUM_CH-1:0]            rep_periodic_q, rep_periodic_d;

    // Repeat timer: runs only while a channel stays accepted-pressed, first interval is the delay.
    always_comb begin
        rep_cnt_d      = rep_cnt_q;
        rep_periodic_d = rep_periodic_q;
        rep_fire_s     = {NUM_CH{1'b0}};
        for (int ch = 0; ch < NUM_CH; ch++) begin
            if (level_q[ch] && level_d[ch]) begin
                if (rep_cnt_q[ch] == (rep_periodic_q[ch] ? REP_W'(REPEAT_PERIOD - 1)
                                                         : REP_W'(REPEAT_DELAY - 1))) begin
                    rep_fire_s[ch]     = 1'b1;
                    rep_cnt_d[ch]      = {REP_W{1'b0}};
                    rep_periodic_d[ch] = 1'b1;
                end else begin
                    rep_cnt_d[ch] = rep_cnt_q[ch] + REP_W'(1);
                end
            end else begin
                rep_cnt_d[ch]      = {REP_W{1'b0}};
                rep_periodic_d[ch] = 1'b0;
            end
        end
    end

    // Repeat state registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rep_cnt_q      <= {(NUM_CH*REP_W){1'b0}};
            rep_periodic_q <= {NUM_CH{1'b0}};
        end else begin
            rep_cnt_q      <= rep_cnt_d;
            rep_periodic_q <= rep_periodic_d;
        end
    end
`else
    assign rep_fire_s = {NUM_CH{1'b0}};
`endif

    // Debounce: a new level is taken only after STABLE_CNT consecutive mismatching samples.
    always_comb begin
        sync1_d = raw_s;
        sync2_d = sync1_q;
        level_d = level_q;
        cnt_d   = cnt_q;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            if (sync2_q[ch] == level_q[ch]) begin
                cnt_d[ch] = {CNT_W{1'b0}};
            end else if (cnt_q[ch] == CNT_W'(STABLE_CNT - 1)) begin
                level_d[ch] = sync2_q[ch];
                cnt_d[ch]   = {CNT_W{1'b0}};
            end else begin
                cnt_d[ch] = cnt_q[ch] + CNT_W'(1);
            end
        end
        press_d   = (level_d & ~level_q) | rep_fire_s;
        release_d = ~level_d & level_q;
        any_d     = |press_d;
    end

    // Main state and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q   <= {NUM_CH{1'b0}};
            sync2_q   <= {NUM_CH{1'b0}};
            level_q   <= {NUM_CH{1'b0}};
            cnt_q     <= {(NUM_CH*CNT_W){1'b0}};
            press_q   <= {NUM_CH{1'b0}};
            release_q <= {NUM_CH{1'b0}};
            any_q     <= 1'b0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            level_q   <= level_d;
            cnt_q     <= cnt_d;
            press_q   <= press_d;
            release_q <= release_d;
            any_q     <= any_d;
        end
    end

    assign button_out    = level_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign any_press     = any_q;

endmodule

// File: tb/tb_debounce_bank.sv
// Directed self-checking bench for debounce_bank (NUM_CH=4, STABLE_CNT=4, repeat 20/8).
// Expectations for the repeat test follow whether DEBOUNCE_BANK_REPEAT_EN is defined.
module tb_debounce_bank;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] button_in;
    logic [3:0] button_out;
    logic [3:0] press_pulse;
    logic [3:0] release_pulse;
    logic       any_press;

    int n_tests = 0;
    int n_fail  = 0;

    debounce_bank #(
        .NUM_CH(4), .CNT_W(8), .STABLE_CNT(4), .ACTIVE_LOW(0),
        .REPEAT_DELAY(20), .REPEAT_PERIOD(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .button_in(button_in),
        .button_out(button_out), .press_pulse(press_pulse),
        .release_pulse(release_pulse), .any_press(any_press)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges, leaving time 1 unit after the last one.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    logic [63:0] press_mask;
    logic [63:0] release_mask;
    logic [63:0] exp_press;
    logic [63:0] exp_release;
    logic [3:0]  seen;

    initial begin
        rst_n     = 1'b0;
        button_in = 4'b0000;
        step(3);
        check_val("rst_out", {60'd0, button_out}, 64'd0);
        check_val("rst_press", {60'd0, press_pulse}, 64'd0);
        check_val("rst_release", {60'd0, release_pulse}, 64'd0);
        check_val("rst_any", {63'd0, any_press}, 64'd0);

        rst_n = 1'b1;
        seen  = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            step(1);
            seen = seen | press_pulse | release_pulse;
        end
        check_val("rst_exit_nopulse", {60'd0, seen}, 64'd0);

        // Clean press on channel 0: accepted at edge E0+5.
        button_in = 4'b0001;
        step(5);
        check_val("clean_before_out", {60'd0, button_out}, 64'd0);
        check_val("clean_before_press", {60'd0, press_pulse}, 64'd0);
        step(1);
        check_val("clean_out", {60'd0, button_out}, 64'd1);
        check_val("clean_press", {60'd0, press_pulse}, 64'd1);
        check_val("clean_any", {63'd0, any_press}, 64'd1);
        check_val("clean_release", {60'd0, release_pulse}, 64'd0);
        step(1);
        check_val("clean_press_once", {60'd0, press_pulse}, 64'd0);
        check_val("clean_any_once", {63'd0, any_press}, 64'd0);

        // Hold channel 0, then release; k counts edges since acceptance.
        press_mask   = 64'd0;
        release_mask = 64'd0;
        for (int k = 2; k <= 60; k++) begin
            step(1);
            press_mask[k]   = press_pulse[0];
            release_mask[k] = release_pulse[0];
            if (k == 46) button_in = 4'b0000;
        end
        exp_press = 64'd0;
`ifdef DEBOUNCE_BANK_REPEAT_EN
        exp_press[20] = 1'b1;
        exp_press[28] = 1'b1;
        exp_press[36] = 1'b1;
        exp_press[44] = 1'b1;
`endif
        exp_release     = 64'd0;
        exp_release[52] = 1'b1;
        check_val("repeat_press_mask", press_mask, exp_press);
        check_val("release_mask", release_mask, exp_release);
        check_val("release_out", {60'd0, button_out}, 64'd0);

        // Bounce on channel 1: 1,0,1,0,1 then hold 1.
        seen = 4'b0000;
        button_in = 4'b0010; step(1); seen = seen | press_pulse | button_out;
        button_in = 4'b0000; step(1); seen = seen | press_pulse | button_out;
        button_in = 4'b0010; step(1); seen = seen | press_pulse | button_out;
        button_in = 4'b0000; step(1); seen = seen | press_pulse | button_out;
        button_in = 4'b0010; step(1); seen = seen | press_pulse | button_out;
        for (int i = 0; i < 4; i++) begin
            step(1);
            seen = seen | press_pulse | button_out;
        end
        check_val("bounce_quiet", {60'd0, seen}, 64'd0);
        step(1);
        check_val("bounce_out", {60'd0, button_out}, 64'h2);
        check_val("bounce_press", {60'd0, press_pulse}, 64'h2);
        step(1);
        check_val("bounce_press_once", {60'd0, press_pulse}, 64'd0);

        // Simultaneous press then release on channels 2 and 3.
        button_in = 4'b1110;
        step(6);
        check_val("sim_press", {60'd0, press_pulse}, 64'hC);
        check_val("sim_any", {63'd0, any_press}, 64'd1);
        check_val("sim_out_on", {60'd0, button_out}, 64'hE);
        button_in = 4'b0010;
        step(5);
        check_val("sim_release_early", {60'd0, release_pulse}, 64'd0);
        step(1);
        check_val("sim_release", {60'd0, release_pulse}, 64'hC);
        check_val("sim_out_off", {60'd0, button_out}, 64'h2);
        check_val("sim_no_press", {60'd0, press_pulse}, 64'd0);

        // Reset at the third mismatch edge on channel 0.
        button_in = 4'b0011;
        step(4);
        rst_n = 1'b0;
        step(1);
        check_val("midrst_out", {60'd0, button_out}, 64'd0);
        check_val("midrst_pulses", {56'd0, press_pulse, release_pulse}, 64'd0);
        check_val("midrst_any", {63'd0, any_press}, 64'd0);
        rst_n = 1'b1;
        seen  = 4'b0000;
        for (int i = 0; i < 5; i++) begin
            step(1);
            seen = seen | press_pulse | release_pulse | button_out;
        end
        check_val("midrst_quiet", {60'd0, seen}, 64'd0);
        step(1);
        check_val("midrst_out_after", {60'd0, button_out}, 64'h3);
        check_val("midrst_press", {60'd0, press_pulse}, 64'h3);
        check_val("midrst_any_after", {63'd0, any_press}, 64'd1);
        step(1);
        check_val("midrst_press_once", {60'd0, press_pulse}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/debounce_bank.md
DEBOUNCE_BANK -- requirements
Module: debounce_bank

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of independent button channels, range 1..32.
REQ-002 SHALL have parameter CNT_W, default 20: width of each per-channel stability counter.
REQ-003 SHALL have parameter STABLE_CNT, default 500000: consecutive mismatching cycles required to accept a new level, range 2..2^CNT_W-1.
REQ-004 SHALL have parameter ACTIVE_LOW, default 0: when 1, raw inputs are inverted before synchronisation so a pressed button reads 1.
REQ-005 SHALL have parameter REPEAT_DELAY, default 50000000: cycles from accepted press to first repeat pulse; used only when DEBOUNCE_BANK_REPEAT_EN is defined.
REQ-006 SHALL have parameter REPEAT_PERIOD, default 10000000: cycles between subsequent repeat pulses; used only when DEBOUNCE_BANK_REPEAT_EN is defined.
REQ-007 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-008 SHALL have port rst_n, input, 1: reset, synchronous and active-low.
REQ-009 SHALL have port button_in, input, NUM_CH: raw asynchronous button inputs, one bit per channel.
REQ-010 SHALL have port button_out, output, NUM_CH: debounced level per channel, 1 = pressed.
REQ-011 SHALL have port press_pulse, output, NUM_CH: one-cycle pulse per accepted press (plus repeat pulses when enabled).
REQ-012 SHALL have port release_pulse, output, NUM_CH: one-cycle pulse per accepted release.
REQ-013 SHALL have port any_press, output, 1: registered OR of all press_pulse bits, same cycle as press_pulse.

Function
REQ-014 Each channel SHALL pass its (optionally inverted) input through a 2-flop synchroniser; sync value s reflects a raw change sampled at edge E0 from after edge E0+1.
REQ-015 On each edge where s != button_out[ch], the channel counter SHALL increment; on each edge where s == button_out[ch], the counter SHALL clear to 0.
REQ-016 On the edge where s != button_out[ch] and counter == STABLE_CNT-1, button_out[ch] SHALL take s and the counter SHALL clear; level change therefore occurs at edge E0+STABLE_CNT+1 for a clean input.
REQ-017 Any single-cycle return of s to the current level SHALL restart the full STABLE_CNT count; the counter SHALL never wrap.
REQ-018 press_pulse[ch] SHALL be 1 for exactly the one cycle following the edge where button_out[ch] goes 0->1; release_pulse[ch] likewise for 1->0.
REQ-019 Channels SHALL be fully independent; simultaneous transitions on several channels SHALL produce simultaneous pulses on each.
REQ-020 press_pulse and release_pulse for one channel SHALL never be 1 in the same cycle.

Reset
REQ-021 While rst_n is 0 at a clock edge, synchronisers, counters, button_out, press_pulse, release_pulse, any_press and repeat state SHALL all become 0.
REQ-022 Reset asserted mid-count SHALL discard the partial count; a button held through reset SHALL be accepted as a fresh press STABLE_CNT+2 edges after rst_n rises, with a press_pulse.
REQ-023 No pulse SHALL be generated by reset entry or exit itself.

Configuration
REQ-024 With macro DEBOUNCE_BANK_REPEAT_EN defined, a per-channel repeat counter SHALL run while button_out[ch]=1: extra press_pulse at REPEAT_DELAY cycles after the accepted press, then every REPEAT_PERIOD cycles, cleared immediately on release or reset.
REQ-025 Without DEBOUNCE_BANK_REPEAT_EN, no repeat logic SHALL be synthesised; press_pulse occurs only on 0->1 transitions and REPEAT_* parameters are ignored.

Verification (bench: NUM_CH=4, STABLE_CNT=4, ACTIVE_LOW=0, REPEAT_DELAY=20, REPEAT_PERIOD=8)
REQ-026 Clean press: button_in[0] 0->1 before edge E0 -> button_out[0]=1 after edge E0+5, press_pulse[0] and any_press high for one cycle, others 0.
REQ-027 Bounce: button_in[1] toggles 1,0,1,0,1 each cycle then holds 1 -> no pulse during bounce; button_out[1]=1 exactly 5 edges after the last 0->1 sampling edge.
REQ-028 Release and simultaneity: channels 2 and 3 released on same cycle -> release_pulse=4'b1100 in one cycle, button_out[3:2]=0.
REQ-029 Reset mid-count: rst_n=0 at the third mismatch edge on channel 0 with input held 1 -> all outputs 0; press accepted 6 edges after rst_n=1, one press_pulse.
REQ-030 Repeat (macro defined): hold channel 0 for 50 cycles after acceptance -> press_pulse[0] at +0, +20, +28, +36, +44; none after release; without macro only the +0 pulse.
